// File: rtl/btt_pkg.sv
// rtl/btt_pkg.sv - shared types and sizes for the branch-target table
package btt_pkg;

    localparam int BTT_ADDR_W = 5;
    localparam int BTT_TGT_W  = 10;

    typedef enum logic {BTT_ABS, BTT_REL} btt_mode_e;

    typedef struct packed {
        logic                 valid;
        btt_mode_e            mode;
        logic [BTT_TGT_W-1:0] data;
    } btt_entry_t;

endpackage

// File: rtl/btt_resolve.sv
// rtl/btt_resolve.sv - turns one table entry plus the branch PC into a target and hit flag
module btt_resolve
    import btt_pkg::*;
(
    input  btt_entry_t           i_entry,
    input  logic [BTT_TGT_W-1:0] i_pc,
    output logic [BTT_TGT_W-1:0] o_target,
    output logic                 o_hit
);

    always_comb begin
        o_hit    = i_entry.valid;
        o_target = i_pc + BTT_TGT_W'(1);
        // Both adders wrap naturally at the PC width.
        if (i_entry.valid) begin
            if (i_entry.mode == BTT_REL) begin
                o_target = i_pc + i_entry.data;
            end else begin
                o_target = i_entry.data;
            end
        end
    end

endmodule

// File: rtl/branch_target_table.sv
// rtl/branch_target_table.sv - writable branch-target table with registered hit/miss lookup
module branch_target_table
    import btt_pkg::*;
#(
    parameter int ADDR_W = BTT_ADDR_W,
    parameter int TGT_W  = BTT_TGT_W,
    parameter bit REL_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_wr_mode,
    input  logic [TGT_W-1:0]  i_wr_data,
    input  logic              i_clr_all,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [TGT_W-1:0]  i_pc,
    output logic [TGT_W-1:0]  o_target,
    output logic              o_hit,
    output logic              o_rd_valid,
    output logic              o_wr_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    btt_entry_t             r_entries [DEPTH];
    btt_entry_t             w_new_entry;
    btt_entry_t             w_rd_entry;
    logic                   w_wr_take;
    logic [BTT_TGT_W-1:0]   w_target;
    logic                   w_hit;

    // A clear in the same cycle suppresses the write entirely.
    assign w_wr_take = i_wr_en && !i_clr_all;

    always_comb begin
        w_new_entry       = '0;
        w_new_entry.valid = 1'b1;
        w_new_entry.mode  = btt_mode_e'(i_wr_mode & REL_EN);
        w_new_entry.data  = i_wr_data;
    end

    assign w_rd_entry = (w_wr_take && (i_wr_addr == i_rd_addr)) ? w_new_entry
                                                                 : r_entries[i_rd_addr];

    btt_resolve u_resolve (
        .i_entry  (w_rd_entry),
        .i_pc     (i_pc),
        .o_target (w_target),
        .o_hit    (w_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else if (i_wr_en) begin
            r_entries[i_wr_addr] <= w_new_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_target   <= '0;
            o_hit      <= 1'b0;
            o_rd_valid <= 1'b0;
            o_wr_err   <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            o_wr_err   <= i_wr_en && i_clr_all;
            if (i_rd_en) begin
                o_target <= w_target;
                o_hit    <= w_hit;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_table.sv
// tb/tb_branch_target_table.sv - directed table plus randomized model check of branch_target_table
module tb_branch_target_table;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic       wr_mode = 1'b0;
    logic [9:0] wr_data = '0;
    logic       clr_all = 1'b0;
    logic       rd_en = 1'b0;
    logic [4:0] rd_addr = '0;
    logic [9:0] pc = '0;
    logic [9:0] target;
    logic       hit;
    logic       rd_valid;
    logic       wr_err;

    int total = 0;
    int bad = 0;

    bit mv [32];
    bit mm [32];
    int md [32];
    int m_target;
    int m_hit;
    int m_valid;
    int m_err;

    typedef struct {
        bit we; int wa; bit wm; int wd; bit clr; bit re; int ra; int pc;
        int e_valid; int e_hit; int e_target; int e_err;
    } vec_t;
    vec_t vecs [12];

    branch_target_table dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_mode  (wr_mode),
        .i_wr_data  (wr_data),
        .i_clr_all  (clr_all),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .i_pc       (pc),
        .o_target   (target),
        .o_hit      (hit),
        .o_rd_valid (rd_valid),
        .o_wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mv[i] = 1'b0;
        m_target = 0; m_hit = 0; m_valid = 0; m_err = 0;
    endtask

    // One clock cycle: the model predicts from the spec rules, then the DUT is sampled after the edge.
    task automatic do_cycle(input bit we, input int wa, input bit wm, input int wd,
                            input bit clr, input bit re, input int ra, input int p);
        bit v; bit mode; int d;
        wr_en = we; wr_addr = 5'(wa); wr_mode = wm; wr_data = 10'(wd);
        clr_all = clr; rd_en = re; rd_addr = 5'(ra); pc = 10'(p);
        if (re) begin
            if (we && !clr && wa == ra) begin
                v = 1'b1; mode = wm; d = wd;
            end else begin
                v = mv[ra]; mode = mm[ra]; d = md[ra];
            end
            m_hit = v;
            if (!v) m_target = (p + 1) % 1024;
            else if (mode) m_target = (p + d) % 1024;
            else m_target = d;
        end
        m_valid = re;
        m_err = (we && clr) ? 1 : 0;
        if (clr) begin
            for (int i = 0; i < 32; i++) mv[i] = 1'b0;
        end else if (we) begin
            mv[wa] = 1'b1; mm[wa] = wm; md[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0; clr_all = 1'b0; rd_en = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_hit", int'(hit), 0);
        chk("reset_target", int'(target), 0);
        chk("reset_wr_err", int'(wr_err), 0);
        model_reset();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(bit we, int wa, bit wm, int wd, bit clr, bit re, int ra, int p,
                                int ev, int eh, int et, int ee);
        vec_t r;
        r.we = we; r.wa = wa; r.wm = wm; r.wd = wd; r.clr = clr; r.re = re; r.ra = ra; r.pc = p;
        r.e_valid = ev; r.e_hit = eh; r.e_target = et; r.e_err = ee;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 0, 0,     0, 1, 3, 'h040, 1, 0, 'h041, 0);
        vecs[1]  = mk(1, 0, 0, 'h01C, 0, 0, 0, 0,     0, 0, 'h041, 0);
        vecs[2]  = mk(0, 0, 0, 0,     0, 1, 0, 'h010, 1, 1, 'h01C, 0);
        vecs[3]  = mk(1, 2, 1, 'h3F0, 0, 0, 0, 0,     0, 1, 'h01C, 0);
        vecs[4]  = mk(0, 0, 0, 0,     0, 1, 2, 'h064, 1, 1, 'h054, 0);
        vecs[5]  = mk(0, 0, 0, 0,     0, 1, 2, 'h005, 1, 1, 'h3F5, 0);
        vecs[6]  = mk(1, 5, 0, 'h077, 0, 1, 5, 'h000, 1, 1, 'h077, 0);
        vecs[7]  = mk(1, 1, 0, 'h0AA, 1, 1, 0, 'h000, 1, 1, 'h01C, 1);
        vecs[8]  = mk(0, 0, 0, 0,     0, 1, 0, 'h100, 1, 0, 'h101, 0);
        vecs[9]  = mk(0, 0, 0, 0,     0, 1, 1, 'h3FF, 1, 0, 'h000, 0);
        vecs[10] = mk(0, 0, 0, 0,     0, 1, 2, 'h020, 1, 0, 'h021, 0);
        vecs[11] = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 'h021, 0);

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            do_cycle(vecs[i].we, vecs[i].wa, vecs[i].wm, vecs[i].wd,
                     vecs[i].clr, vecs[i].re, vecs[i].ra, vecs[i].pc);
            chk($sformatf("vec%0d_rd_valid", i), int'(rd_valid), vecs[i].e_valid);
            chk($sformatf("vec%0d_hit", i), int'(hit), vecs[i].e_hit);
            chk($sformatf("vec%0d_target", i), int'(target), vecs[i].e_target);
            chk($sformatf("vec%0d_wr_err", i), int'(wr_err), vecs[i].e_err);
        end

        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(1, 0) == 1, $urandom_range(7, 0), $urandom_range(1, 0) == 1,
                     $urandom_range(1023, 0), $urandom_range(15, 0) == 0,
                     $urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(1023, 0));
            chk("rand_rd_valid", int'(rd_valid), m_valid);
            chk("rand_hit", int'(hit), m_hit);
            chk("rand_target", int'(target), m_target);
            chk("rand_wr_err", int'(wr_err), m_err);
        end

        // Lookup immediately followed by reset: pending result discarded, table emptied.
        do_cycle(1, 6, 0, 'h155, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 1, 6, 'h010);
        chk("prereset_hit", int'(hit), 1);
        chk("prereset_target", int'(target), 'h155);
        do_reset();
        for (int a = 0; a < 8; a++) begin
            do_cycle(0, 0, 0, 0, 0, 1, a, 'h200 + a);
            chk($sformatf("postreset_hit%0d", a), int'(hit), 0);
            chk($sformatf("postreset_target%0d", a), int'(target), 'h201 + a);
        end
        do_cycle(0, 0, 0, 0, 0, 1, 6, 'h3FF);
        chk("postreset_wrap", int'(target), 'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
